// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-stage controller.
// Opcodes, FSM state encoding and the timeout exception payload.
package mem_stage_pkg;

  localparam logic [4:0]  OP_SW           = 5'b00111;
  localparam logic [4:0]  OP_LW           = 5'b01000;
  localparam logic [31:0] EXC_MEM_TIMEOUT = 32'd6;
  localparam logic [4:0]  EXC_RD          = 5'd30;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // True for opcodes that access data memory.
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Request-cycle counter for the memory-stage timeout.
// Counts while enabled, clears synchronously, saturates at TIMEOUT-1 and
// flags that terminal count.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, then increment until the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: passes non-memory ops through in one cycle and
// runs a two-state IDLE/REQ handshake with data memory for lw/sw, stalling
// the upstream pipeline until the access completes.
// Optional feature: define MEM_TIMEOUT_EN to abort a request that sees no
// ack within TIMEOUT cycles, producing a memory-timeout exception result.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       ir_in,
  input  logic [31:0]       o_in,
  input  logic [31:0]       b_in,
  input  logic [4:0]        rd_in,
  input  logic              ex_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic [31:0]       ir_out,
  output logic [31:0]       o_out,
  output logic [31:0]       d_out,
  output logic [4:0]        rd_out,
  output logic              ex_out
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       o_q, o_d;
  logic [31:0]       d_q, d_d;
  logic [4:0]        rd_q, rd_d;
  logic              ex_q, ex_d;
  logic              stall_c;
  logic              timeout;
  logic [4:0]        op;

  assign op = ir_in[31:27];

`ifdef MEM_TIMEOUT_EN
  logic ctr_clear;
  logic ctr_en;
  logic ctr_tc;

  // Counter restarts from zero on every REQ entry and runs only in REQ.
  assign ctr_clear = (state_q == IDLE);
  assign ctr_en    = (state_q == REQ);
  assign timeout   = ctr_tc && (state_q == REQ);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (clr),
    .clear (ctr_clear),
    .en    (ctr_en),
    .tc    (ctr_tc)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state, memory-port and result-register logic for the IDLE/REQ FSM.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ir_d    = ir_q;
    o_d     = o_q;
    d_d     = d_q;
    rd_d    = rd_q;
    ex_d    = ex_q;
    stall_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (is_mem_op(op) && !ex_in) begin
          // Launch the access; memory-port values are captured here and
          // stay stable for the whole request.
          stall_c = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = (op == OP_SW);
          addr_d  = o_in[ADDR_W-1:0];
          wdata_d = b_in;
        end else begin
          // Non-memory or excepted instruction: single-cycle pass-through.
          ir_d = ir_in;
          o_d  = o_in;
          d_d  = '0;
          rd_d = rd_in;
          ex_d = ex_in;
        end
      end

      REQ: begin
        if (dmem_ack) begin
          // Ack has priority over a coinciding timeout.
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          ir_d    = ir_in;
          o_d     = o_in;
          d_d     = we_q ? 32'd0 : dmem_rdata;
          rd_d    = rd_in;
          ex_d    = ex_in;
        end else if (timeout) begin
          // Abandon the access and retire it as a memory-timeout exception.
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          ir_d    = ir_in;
          o_d     = EXC_MEM_TIMEOUT;
          d_d     = '0;
          rd_d    = EXC_RD;
          ex_d    = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, memory-port and result registers; reset clears everything at once.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ir_q    <= '0;
      o_q     <= '0;
      d_q     <= '0;
      rd_q    <= '0;
      ex_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ir_q    <= ir_d;
      o_q     <= o_d;
      d_q     <= d_d;
      rd_q    <= rd_d;
      ex_q    <= ex_d;
    end
  end

  // Stall is combinational; it is forced low while reset is asserted.
  assign stall      = clr & stall_c;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign ir_out     = ir_q;
  assign o_out      = o_q;
  assign d_out      = d_q;
  assign rd_out     = rd_q;
  assign ex_out     = ex_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl. Expected results are queued when an
// instruction is driven and popped when the DUT retires it. The timeout
// scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int TB_TIMEOUT = 4;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] o;
    logic [31:0] d;
    logic [4:0]  rd;
    logic        ex;
  } res_t;

  logic              clk;
  logic              clr;
  logic [31:0]       ir_in, o_in, b_in;
  logic [4:0]        rd_in;
  logic              ex_in;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata, dmem_rdata;
  logic              dmem_ack;
  logic              stall;
  logic [31:0]       ir_out, o_out, d_out;
  logic [4:0]        rd_out;
  logic              ex_out;

  res_t sb[$];
  res_t exp_r, last_r, act_r;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_stage_ctrl #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .ir_in      (ir_in),
    .o_in       (o_in),
    .b_in       (b_in),
    .rd_in      (rd_in),
    .ex_in      (ex_in),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .stall      (stall),
    .ir_out     (ir_out),
    .o_out      (o_out),
    .d_out      (d_out),
    .rd_out     (rd_out),
    .ex_out     (ex_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t sample_out();
    return {ir_out, o_out, d_out, rd_out, ex_out};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [26:0] low);
    return {op, low};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                       input logic [4:0] rd, input logic ex);
    ir_in = ir;
    o_in  = o;
    b_in  = b;
    rd_in = rd;
    ex_in = ex;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive(mk_ir(OP_LW, 27'h0), 32'h40, 32'h9, 5'd1, 1'b0);
    #2;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if ({dmem_req, dmem_we} !== 2'b00) $display("FAIL rst_req_we: got %b want 00", {dmem_req, dmem_we}); else n_pass++;
    n_checks++; if ({dmem_addr, dmem_wdata} !== '0) $display("FAIL rst_addr_wdata: got %h want 0", {dmem_addr, dmem_wdata}); else n_pass++;
    act_r = sample_out();
    n_checks++; if (act_r !== '0) $display("FAIL rst_outputs: got %h want 0", act_r); else n_pass++;
    step();
    n_checks++; if (sample_out() !== '0) $display("FAIL rst_hold_clock: got %h want 0", sample_out()); else n_pass++;
    // Release with a bubble presented; the first edge after release loads it.
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    clr = 1'b1;
    step();
    last_r = '0;
  endtask

  task automatic test_alu();
    logic [31:0] ir;
    ir = mk_ir(5'b00000, 27'h0000ABC);
    drive(ir, 32'h1234, 32'h0, 5'd3, 1'b0);
    sb.push_back({ir, 32'h1234, 32'h0, 5'd3, 1'b0});
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall); else n_pass++;
    step();
    exp_r = sb.pop_front();
    act_r = sample_out();
    n_checks++; if (act_r !== exp_r) $display("FAIL alu_result: got %h want %h", act_r, exp_r); else n_pass++;
    n_checks++; if ({stall, dmem_req} !== 2'b00) $display("FAIL alu_stall_after: got %b want 00", {stall, dmem_req}); else n_pass++;
    last_r = exp_r;
  endtask

  task automatic test_lw_wait();
    logic [31:0] ir;
    int stall_cnt;
    stall_cnt = 0;
    ir = mk_ir(OP_LW, 27'h1);
    drive(ir, 32'h0000_0010, 32'h0, 5'd5, 1'b0);
    dmem_ack = 1'b0;
    sb.push_back({ir, 32'h0000_0010, 32'hDEADBEEF, 5'd5, 1'b0});
    #1;
    if (stall === 1'b1) stall_cnt++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL lw_req_idle: got %b want 0", dmem_req); else n_pass++;
    step();
    for (int k = 0; k < 3; k++) begin
      n_checks++; if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 12'h010})
        $display("FAIL lw_req_cycle%0d: got req=%b we=%b addr=%h want 1 0 010", k, dmem_req, dmem_we, dmem_addr); else n_pass++;
      act_r = sample_out();
      n_checks++; if (act_r !== last_r) $display("FAIL lw_hold%0d: got %h want %h", k, act_r, last_r); else n_pass++;
      if (stall === 1'b1) stall_cnt++;
      step();
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL lw_ack_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (stall_cnt !== 4) $display("FAIL lw_stall_cycles: got %0d want 4", stall_cnt); else n_pass++;
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    exp_r = sb.pop_front();
    act_r = sample_out();
    n_checks++; if (act_r !== exp_r) $display("FAIL lw_result: got %h want %h", act_r, exp_r); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL lw_req_drop: got %b want 0", dmem_req); else n_pass++;
    last_r = exp_r;
  endtask

  task automatic test_sw();
    logic [31:0] ir;
    int stall_cnt;
    stall_cnt = 0;
    ir = mk_ir(OP_SW, 27'h2);
    drive(ir, 32'h20, 32'hCAFE0001, 5'd7, 1'b0);
    sb.push_back({ir, 32'h20, 32'h0, 5'd7, 1'b0});
    #1;
    if (stall === 1'b1) stall_cnt++;
    step();
    n_checks++; if ({dmem_req, dmem_we} !== 2'b11) $display("FAIL sw_req_we: got %b want 11", {dmem_req, dmem_we}); else n_pass++;
    n_checks++; if (dmem_wdata !== 32'hCAFE0001) $display("FAIL sw_wdata: got %h want cafe0001", dmem_wdata); else n_pass++;
    n_checks++; if (dmem_addr !== 12'h020) $display("FAIL sw_addr: got %h want 020", dmem_addr); else n_pass++;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_5555;
    #1;
    if (stall === 1'b1) stall_cnt++;
    n_checks++; if (stall_cnt !== 1) $display("FAIL sw_stall_cycles: got %0d want 1", stall_cnt); else n_pass++;
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    exp_r = sb.pop_front();
    act_r = sample_out();
    n_checks++; if (act_r !== exp_r) $display("FAIL sw_result: got %h want %h", act_r, exp_r); else n_pass++;
    n_checks++; if ({dmem_req, dmem_we} !== 2'b00) $display("FAIL sw_release: got %b want 00", {dmem_req, dmem_we}); else n_pass++;
    last_r = exp_r;
  endtask

  task automatic test_back_to_back();
    logic [31:0] b2b_o    [2];
    logic [11:0] b2b_a    [2];
    logic [31:0] b2b_data [2];
    logic [31:0] ir;
    b2b_o    = '{32'h0000_0100, 32'hFFFF_F204};
    b2b_a    = '{12'h100, 12'h204};
    b2b_data = '{32'h1111_1111, 32'h2222_2222};
    for (int i = 0; i < 2; i++) begin
      ir = mk_ir(OP_LW, 27'(i + 16));
      drive(ir, b2b_o[i], 32'h0, 5'd0, 1'b0);
      // Ack presented while idle must not complete anything.
      dmem_ack = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      sb.push_back({ir, b2b_o[i], b2b_data[i], 5'd0, 1'b0});
      #1;
      n_checks++; if ({stall, dmem_req} !== 2'b10) $display("FAIL b2b_idle%0d: got stall/req %b want 10", i, {stall, dmem_req}); else n_pass++;
      step();
      n_checks++; if ({dmem_req, dmem_addr} !== {1'b1, b2b_a[i]}) $display("FAIL b2b_req%0d: got %b %h want 1 %h", i, dmem_req, dmem_addr, b2b_a[i]); else n_pass++;
      dmem_rdata = b2b_data[i];
      step();
      dmem_ack = 1'b0;
      exp_r = sb.pop_front();
      act_r = sample_out();
      n_checks++; if (act_r !== exp_r) $display("FAIL b2b_result%0d: got %h want %h", i, act_r, exp_r); else n_pass++;
    end
    dmem_rdata = 32'h0;
    last_r = exp_r;
  endtask

  task automatic test_exc();
    logic [31:0] ir;
    ir = mk_ir(OP_LW, 27'h3);
    drive(ir, 32'h44, 32'h0, 5'd9, 1'b1);
    sb.push_back({ir, 32'h44, 32'h0, 5'd9, 1'b1});
    #1;
    n_checks++; if ({stall, dmem_req} !== 2'b00) $display("FAIL exc_idle: got stall/req %b want 00", {stall, dmem_req}); else n_pass++;
    step();
    exp_r = sb.pop_front();
    act_r = sample_out();
    n_checks++; if (act_r !== exp_r) $display("FAIL exc_result: got %h want %h", act_r, exp_r); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL exc_no_req: got %b want 0", dmem_req); else n_pass++;
    last_r = exp_r;
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] ir;
    ir = mk_ir(OP_LW, 27'h4);
    drive(ir, 32'h80, 32'h0, 5'd4, 1'b0);
    #1;
    step();
    n_checks++; if (dmem_req !== 1'b1) $display("FAIL mid_req_before: got %b want 1", dmem_req); else n_pass++;
    clr = 1'b0;
    #1;
    n_checks++; if ({dmem_req, dmem_we, stall} !== 3'b000) $display("FAIL mid_req_async: got req/we/stall %b want 000", {dmem_req, dmem_we, stall}); else n_pass++;
    act_r = sample_out();
    n_checks++; if (act_r !== '0) $display("FAIL mid_req_outputs: got %h want 0", act_r); else n_pass++;
    step();
    clr = 1'b1;
    #1;
    n_checks++; if ({stall, dmem_req} !== 2'b10) $display("FAIL mid_req_idle_after: got stall/req %b want 10", {stall, dmem_req}); else n_pass++;
    sb.push_back({ir, 32'h80, 32'hA5A5_A5A5, 5'd4, 1'b0});
    step();
    n_checks++; if (dmem_req !== 1'b1) $display("FAIL mid_req_reissue: got %b want 1", dmem_req); else n_pass++;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hA5A5_A5A5;
    step();
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    exp_r = sb.pop_front();
    act_r = sample_out();
    n_checks++; if (act_r !== exp_r) $display("FAIL mid_req_result: got %h want %h", act_r, exp_r); else n_pass++;
    last_r = exp_r;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] ir;
    ir = mk_ir(OP_LW, 27'h5);
    drive(ir, 32'h30, 32'h0, 5'd2, 1'b0);
    dmem_ack = 1'b0;
    sb.push_back({ir, 32'd6, 32'h0, 5'd30, 1'b1});
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL to_idle_stall: got %b want 1", stall); else n_pass++;
    step();
    for (int k = 0; k < TB_TIMEOUT - 1; k++) begin
      n_checks++; if ({stall, dmem_req} !== 2'b11) $display("FAIL to_wait%0d: got stall/req %b want 11", k, {stall, dmem_req}); else n_pass++;
      step();
    end
    n_checks++; if (stall !== 1'b0) $display("FAIL to_expire_stall: got %b want 0", stall); else n_pass++;
    step();
    exp_r = sb.pop_front();
    act_r = sample_out();
    n_checks++; if (act_r !== exp_r) $display("FAIL to_result: got %h want %h", act_r, exp_r); else n_pass++;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL to_req_drop: got %b want 0", dmem_req); else n_pass++;
    last_r = exp_r;
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_lw_wait();
    test_sw();
    test_back_to_back();
    test_exc();
    test_reset_mid_req();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
